// File: rtl/gb_host_master_if.sv
// Command/response streams and ghostbus signals of the host-side ghostbus master.
interface gb_host_master_if #(
  parameter int GB_AW = 12,
  parameter int GB_DW = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [GB_AW-1:0] cmd_addr;
  logic [GB_DW-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_we;
  logic [GB_AW-1:0] rsp_addr;
  logic [GB_DW-1:0] rsp_data;
  logic [GB_AW-1:0] gb_addr;
  logic [GB_DW-1:0] gb_dout;
  logic [GB_DW-1:0] gb_din;
  logic             gb_we;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready, gb_din,
    output cmd_ready, rsp_valid, rsp_we, rsp_addr, rsp_data, gb_addr, gb_dout, gb_we
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready, gb_din,
    input  cmd_ready, rsp_valid, rsp_we, rsp_addr, rsp_data, gb_addr, gb_dout, gb_we
  );
endinterface

// File: rtl/gb_host_master.sv
// Ghostbus upstream master: one command in, one ghostbus transaction, one response out.
// state  | meaning
// IDLE   | ready for a command
// WRITE  | gb_we pulse cycle
// RDWAIT | counting down the read latency
// RESP   | response held until rsp_ready
module gb_host_master #(
  parameter int GB_AW   = 12,
  parameter int GB_DW   = 32,
  parameter int RDDELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gb_host_master_if.master     bus
);
  typedef enum logic [1:0] {IDLE, WRITE, RDWAIT, RESP} state_t;

  localparam logic [3:0] RD_LOAD = 4'(RDDELAY - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [GB_AW-1:0] gb_addr_q;
  logic [GB_DW-1:0] gb_dout_q;
  logic             gb_we_q;
  logic             rsp_valid_q;
  logic             rsp_we_q;
  logic [GB_AW-1:0] rsp_addr_q;
  logic [GB_DW-1:0] rsp_data_q;

  assign bus.cmd_ready = (state == IDLE) && rst_n;
  assign bus.gb_addr   = gb_addr_q;
  assign bus.gb_dout   = gb_dout_q;
  assign bus.gb_we     = gb_we_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            gb_addr_q  <= bus.cmd_addr;
            rsp_addr_q <= bus.cmd_addr;
            rsp_we_q   <= bus.cmd_we;
            if (bus.cmd_we) begin
              gb_dout_q <= bus.cmd_data;
              gb_we_q   <= 1'b1;
              state     <= WRITE;
            end else begin
              gb_dout_q <= '0;
              gb_we_q   <= 1'b0;
              cnt       <= RD_LOAD;
              state     <= RDWAIT;
            end
          end
        end
        WRITE: begin
          // gb_dout still carries the accepted write data, so it doubles as the echo source
          gb_we_q     <= 1'b0;
          rsp_data_q  <= gb_dout_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RDWAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data_q  <= bus.gb_din;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
